// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory req/ack port plus the decode valid/ready port.
// The master modport is the fetch unit; the slave modport is its environment (imem + decode).
interface fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic [1:0]       npc_sel;
  logic             br_eq;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output id_valid, id_inst, id_pc,
    input  id_ready, npc_sel, br_eq,
    output fetch_cnt, wait_cnt
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  id_valid, id_inst, id_pc,
    output id_ready, npc_sel, br_eq,
    input  fetch_cnt, wait_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: one imem word per req/ack, held for decode until accepted,
// then the next PC is formed from decode's npc_sel and the branch compare.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             ack_hit;
  logic             accept;
  logic [31:0]      pc4;
  logic [31:0]      jmp_tgt;
  logic [31:0]      br_off;
  logic [31:0]      npc;

  assign ack_hit = (state_q == S_REQ)  && bus.imem_ack;
  assign accept  = (state_q == S_HOLD) && bus.id_ready;

  // Next-PC datapath; everything wraps mod 2^32 by plain 32-bit arithmetic.
  assign pc4     = pc_q + 32'd4;
  assign jmp_tgt = {pc4[31:28], inst_q[25:0], 2'b00};
  assign br_off  = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    npc = pc4;
    case (bus.npc_sel)
      SEL_SEQ:  npc = pc4;
      SEL_JUMP: npc = jmp_tgt;
      SEL_BR:   npc = bus.br_eq ? (pc4 + br_off) : pc4;
      default:  npc = pc4;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ack_hit) begin
          inst_d      = bus.imem_rdata;
          fetch_cnt_d = fetch_cnt_q + 1'b1;
          state_d     = S_HOLD;
        end else begin
          wait_cnt_d  = wait_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        // npc_sel/br_eq only matter here, in the accept cycle.
        if (accept) begin
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; address and held word come straight from registers
  always_comb begin
    bus.imem_req  = (state_q == S_REQ);
    bus.id_valid  = (state_q == S_HOLD);
    bus.imem_addr = pc_q;
    bus.id_pc     = pc_q;
    bus.id_inst   = inst_q;
    bus.fetch_cnt = fetch_cnt_q;
    bus.wait_cnt  = wait_cnt_q;
  end

endmodule
